fwd_hazard_ctrl: RTL and testbench

Forwarding and load-use hazard controller for the 5-stage MIPS pipeline. It tracks destination-register metadata through the ID/EX, EX/MEM and MEM/WB stages. It generates the 2-bit select codes that drive the two 3-to-1 ALU-operand multiplexers in EX. It also asserts a one-cycle stall whenever an instruction in ID consumes the result of a load currently in EX, and it keeps a saturating count of stall cycles for performance inspection.

---
 rtl/fwd_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for the 5-stage MIPS pipeline.
// Tracks destination metadata through ID/EX, EX/MEM and MEM/WB.
module fwd_hazard_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [4:0]       id_dest,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             flush,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int unsigned REG_W = 5;
   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_WB  = 2'b10;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic             uses_rs;
      logic             uses_rt;
      logic [REG_W-1:0] dest;
      logic             regwrite;
      logic             memread;
   } ex_stage_t;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dest;
      logic             regwrite;
   } wr_stage_t;

   ex_stage_t ex_q;
   ex_stage_t id_c;
   wr_stage_t mem_q;
   wr_stage_t wb_q;
   logic      bubble_c;

   // A later stage can supply src when it holds a live, non-$0 write to it.
   function automatic logic producer_hit(input wr_stage_t p, input logic [REG_W-1:0] src);
      return p.valid & p.regwrite & (p.dest != '0) & (p.dest == src);
   endfunction

   always_comb begin
      id_c = '{valid:    id_valid,
               rs:       id_rs,
               rt:       id_rt,
               uses_rs:  id_uses_rs,
               uses_rt:  id_uses_rt,
               dest:     id_dest,
               regwrite: id_regwrite,
               memread:  id_memread};
   end

   // Load-use hazard; a flush kills the consumer so no stall is needed.
   always_comb begin
      stall = id_valid & ex_q.valid & ex_q.memread & (ex_q.dest != '0) &
              ((id_uses_rs & (id_rs == ex_q.dest)) | (id_uses_rt & (id_rt == ex_q.dest))) &
              ~flush;
      bubble_c = stall | flush;
   end

   // Operand selects; the younger producer in EX/MEM wins over MEM/WB.
   always_comb begin
      fwd_a_sel = SEL_RF;
      fwd_b_sel = SEL_RF;
      if (ex_q.valid && ex_q.uses_rs) begin
         if (producer_hit(mem_q, ex_q.rs))     fwd_a_sel = SEL_MEM;
         else if (producer_hit(wb_q, ex_q.rs)) fwd_a_sel = SEL_WB;
      end
      if (ex_q.valid && ex_q.uses_rt) begin
         if (producer_hit(mem_q, ex_q.rt))     fwd_b_sel = SEL_MEM;
         else if (producer_hit(wb_q, ex_q.rt)) fwd_b_sel = SEL_WB;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         mem_q <= '{valid: ex_q.valid, dest: ex_q.dest, regwrite: ex_q.regwrite};
         wb_q  <= mem_q;
         ex_q  <= bubble_c ? '0 : id_c;
      end
   end

   // Saturating stall-cycle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed hazard sequences plus random traffic,
// checked against a producer-distance model of the pipeline.
module tb_fwd_hazard_ctrl;

   localparam int unsigned CNT_W = 4;
   localparam int CMAX = 15;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             id_valid = 1'b0;
   logic [4:0]       id_rs = '0;
   logic [4:0]       id_rt = '0;
   logic             id_uses_rs = 1'b0;
   logic             id_uses_rt = 1'b0;
   logic [4:0]       id_dest = '0;
   logic             id_regwrite = 1'b0;
   logic             id_memread = 1'b0;
   logic             flush = 1'b0;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic             stall;
   logic [CNT_W-1:0] stall_cnt;

   fwd_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit v; int rs; int rt; bit urs; bit urt; int dest; bit rw; bit mr;
   } ins_t;

   // Model: pipe[0] = instruction in EX, pipe[1] = MEM, pipe[2] = WB.
   ins_t pipe [3];
   int   mcnt;
   int   checks = 0;
   int   failures = 0;
   logic [31:0] obs_a, obs_b, obs_st, obs_cnt;

   function automatic ins_t nop();
      ins_t i;
      i = '{v: 0, rs: 0, rt: 0, urs: 0, urt: 0, dest: 0, rw: 0, mr: 0};
      return i;
   endfunction

   function automatic ins_t alu(input int rd, input int rs, input int rt);
      ins_t i;
      i = '{v: 1, rs: rs, rt: rt, urs: 1, urt: 1, dest: rd, rw: 1, mr: 0};
      return i;
   endfunction

   function automatic ins_t lw(input int rt, input int base);
      ins_t i;
      i = '{v: 1, rs: base, rt: rt, urs: 1, urt: 0, dest: rt, rw: 1, mr: 1};
      return i;
   endfunction

   function automatic ins_t rnd_ins();
      ins_t i;
      i.v    = ($urandom_range(7) != 0);
      i.rs   = int'($urandom_range(3));
      i.rt   = int'($urandom_range(3));
      i.urs  = 1'($urandom_range(1));
      i.urt  = 1'($urandom_range(1));
      i.dest = int'($urandom_range(3));
      i.rw   = ($urandom_range(3) != 0);
      i.mr   = 1'($urandom_range(1));
      return i;
   endfunction

   // 0 = register file, 1 = one stage ahead (EX/MEM), 2 = two stages ahead (MEM/WB).
   function automatic int exp_sel(input int src, input bit uses);
      if (!pipe[0].v || !uses) return 0;
      for (int k = 1; k <= 2; k++)
         if (pipe[k].v && pipe[k].rw && pipe[k].dest != 0 && pipe[k].dest == src) return k;
      return 0;
   endfunction

   function automatic bit exp_stall(input ins_t i, input bit fl);
      if (fl || !i.v || !pipe[0].v || !pipe[0].mr || pipe[0].dest == 0) return 0;
      return (i.urs && i.rs == pipe[0].dest) || (i.urt && i.rt == pipe[0].dest);
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 3; k++) pipe[k] = nop();
      mcnt = 0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One pipeline cycle: drive ID, check outputs mid-cycle, advance the model.
   task automatic step(input ins_t i, input bit fl);
      int ea, eb;
      bit es;
      id_valid    = i.v;
      id_rs       = 5'(i.rs);
      id_rt       = 5'(i.rt);
      id_uses_rs  = i.urs;
      id_uses_rt  = i.urt;
      id_dest     = 5'(i.dest);
      id_regwrite = i.rw;
      id_memread  = i.mr;
      flush       = fl;
      @(negedge clk);
      ea = exp_sel(pipe[0].rs, pipe[0].urs);
      eb = exp_sel(pipe[0].rt, pipe[0].urt);
      es = exp_stall(i, fl);
      obs_a   = 32'(fwd_a_sel);
      obs_b   = 32'(fwd_b_sel);
      obs_st  = 32'(stall);
      obs_cnt = 32'(stall_cnt);
      check("fwd_a_sel", obs_a, 32'(ea));
      check("fwd_b_sel", obs_b, 32'(eb));
      check("stall", obs_st, 32'(es));
      check("stall_cnt", obs_cnt, 32'(mcnt));
      @(posedge clk);
      if (rst) begin
         model_clear();
      end else begin
         if (es && mcnt < CMAX) mcnt++;
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = (es || fl) ? nop() : i;
      end
      #1;
   endtask

   // Assert reset away from any clock edge, check it takes effect at once, hold 3 cycles.
   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_a", 32'(fwd_a_sel), 32'd0);
      check("rst_async_b", 32'(fwd_b_sel), 32'd0);
      check("rst_async_stall", 32'(stall), 32'd0);
      check("rst_async_cnt", 32'(stall_cnt), 32'd0);
      model_clear();
      for (int k = 0; k < 3; k++) step(rnd_ins(), 1'($urandom_range(1)));
      rst = 1'b0;
   endtask

   initial begin
      model_clear();
      do_reset();

      // EX/MEM then MEM/WB forwarding
      step(alu(3, 1, 2), 0);
      step(alu(4, 3, 5), 0);
      step(alu(6, 7, 3), 0);
      check("exmem_a", obs_a, 32'd1);
      check("exmem_b", obs_b, 32'd0);
      step(nop(), 0);
      check("memwb_a", obs_a, 32'd0);
      check("memwb_b", obs_b, 32'd2);

      // Younger producer wins
      step(alu(3, 1, 2), 0);
      step(alu(3, 4, 5), 0);
      step(alu(8, 3, 3), 0);
      step(nop(), 0);
      check("prio_a", obs_a, 32'd1);
      check("prio_b", obs_b, 32'd1);

      // $0 never forwarded
      step(alu(0, 1, 2), 0);
      step(alu(0, 4, 5), 0);
      step(alu(8, 0, 0), 0);
      step(nop(), 0);
      check("zero_a", obs_a, 32'd0);
      check("zero_b", obs_b, 32'd0);

      // Load-use after a mid-stream reset
      step(lw(2, 1), 0);
      do_reset();
      step(lw(2, 1), 0);
      step(alu(4, 2, 2), 0);
      check("lu_stall", obs_st, 32'd1);
      check("lu_cnt0", obs_cnt, 32'd0);
      step(alu(4, 2, 2), 0);
      check("lu_stall_once", obs_st, 32'd0);
      check("lu_cnt1", obs_cnt, 32'd1);
      step(nop(), 0);
      check("lu_a", obs_a, 32'd2);
      check("lu_b", obs_b, 32'd2);

      // Flush during the hazard cycle
      step(nop(), 0);
      step(nop(), 0);
      step(lw(2, 1), 0);
      step(alu(4, 2, 2), 1);
      check("fl_stall", obs_st, 32'd0);
      step(nop(), 0);
      check("fl_cnt", obs_cnt, 32'd1);
      check("fl_a", obs_a, 32'd0);
      check("fl_b", obs_b, 32'd0);

      // Counter saturation
      do_reset();
      for (int n = 0; n < 20; n++) begin
         step(lw(2, 1), 0);
         step(alu(4, 2, 2), 0);
         step(alu(4, 2, 2), 0);
      end
      step(nop(), 0);
      check("sat_cnt", obs_cnt, 32'd15);

      // Random traffic with an occasional flush and one mid-run reset
      do_reset();
      for (int n = 0; n < 400; n++) begin
         if (n == 200) do_reset();
         step(rnd_ins(), ($urandom_range(7) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
